// File: rtl/alu_share_arbiter_if.sv
// rtl/alu_share_arbiter_if.sv - request, response and ALU signal bundle for the shared-ALU arbiter
interface alu_share_arbiter_if #(
    parameter int DATA_W = 32
);
    logic              req0_valid;
    logic              req0_ready;
    logic [2:0]        req0_op;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;

    logic              req1_valid;
    logic              req1_ready;
    logic [2:0]        req1_op;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;

    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_zero;
    logic              rsp_err;

    logic [2:0]        alu_control;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_data;

    logic              busy;

    // Arbiter side
    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  rsp_ready, alu_data,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_err,
        output alu_control, alu_a, alu_b, busy
    );

    // Requester / consumer / ALU side
    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output rsp_ready, alu_data,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_err,
        input  alu_control, alu_a, alu_b, busy
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one EX-stage ALU between two requesters
module alu_share_arbiter #(
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_share_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_zero_q, rsp_zero_d;
    logic              rsp_err_q, rsp_err_d;
    logic [2:0]        alu_control_q, alu_control_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic              busy_q, busy_d;

    logic              grant;
    logic              req0_ready_c;
    logic              req1_ready_c;
    logic              accept;
    logic [2:0]        sel_op;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;
    logic              sel_legal;

    // Grant: a lone requester wins outright; a tie goes to whoever did not win last time.
    // Readys are gated by rst so nothing looks accepted while the block is held in reset.
    always_comb begin
        grant        = (bus.req0_valid && bus.req1_valid) ? ~last_grant_q : bus.req1_valid;
        req0_ready_c = (state_q == ST_IDLE) && !rst && bus.req0_valid && !grant;
        req1_ready_c = (state_q == ST_IDLE) && !rst && bus.req1_valid &&  grant;
        accept       = req0_ready_c || req1_ready_c;
        sel_op       = grant ? bus.req1_op : bus.req0_op;
        sel_a        = grant ? bus.req1_a  : bus.req0_a;
        sel_b        = grant ? bus.req1_b  : bus.req0_b;
        unique case (sel_op)
            3'b010, 3'b110, 3'b000, 3'b001, 3'b111: sel_legal = 1'b1;
            default:                                sel_legal = 1'b0;
        endcase
    end

    // Next-state and next-output computation for the IDLE -> EXEC -> RESP sequence
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_id_d      = rsp_id_q;
        rsp_data_d    = rsp_data_q;
        rsp_zero_d    = rsp_zero_q;
        rsp_err_d     = rsp_err_q;
        alu_control_d = alu_control_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    last_grant_d = grant;
                    rsp_id_d     = grant;
                    if (sel_legal) begin
                        alu_control_d = sel_op;
                        alu_a_d       = sel_a;
                        alu_b_d       = sel_b;
                        state_d       = ST_EXEC;
                    end else begin
                        // Illegal op never reaches the ALU; answer straight away with an error
                        rsp_err_d   = 1'b1;
                        rsp_data_d  = '0;
                        rsp_zero_d  = 1'b0;
                        rsp_valid_d = 1'b1;
                        state_d     = ST_RESP;
                    end
                end
            end
            ST_EXEC: begin
                // ALU settled on the negedge inside this cycle
                rsp_data_d  = bus.alu_data;
                rsp_zero_d  = (bus.alu_data == '0);
                rsp_err_d   = 1'b0;
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            last_grant_q  <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= 1'b0;
            rsp_data_q    <= '0;
            rsp_zero_q    <= 1'b0;
            rsp_err_q     <= 1'b0;
            alu_control_q <= 3'b000;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_id_q      <= rsp_id_d;
            rsp_data_q    <= rsp_data_d;
            rsp_zero_q    <= rsp_zero_d;
            rsp_err_q     <= rsp_err_d;
            alu_control_q <= alu_control_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.req0_ready  = req0_ready_c;
    assign bus.req1_ready  = req1_ready_c;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_id      = rsp_id_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.rsp_zero    = rsp_zero_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.alu_control = alu_control_q;
    assign bus.alu_a       = alu_a_q;
    assign bus.alu_b       = alu_b_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - directed self-checking bench for alu_share_arbiter
module tb_alu_share_arbiter;
    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    alu_share_arbiter_if #(.DATA_W(32)) bus ();

    alu_share_arbiter #(.DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU evaluating on the falling edge
    always @(negedge clk) begin
        case (bus.alu_control)
            3'b010:  bus.alu_data <= bus.alu_a + bus.alu_b;
            3'b110:  bus.alu_data <= bus.alu_a - bus.alu_b;
            3'b000:  bus.alu_data <= bus.alu_a & bus.alu_b;
            3'b001:  bus.alu_data <= bus.alu_a | bus.alu_b;
            3'b111:  bus.alu_data <= (bus.alu_a < bus.alu_b) ? 32'd1 : 32'd0;
            default: bus.alu_data <= 32'hDEADBEEF;
        endcase
    end

    task automatic idle_inputs();
        bus.req0_valid = 1'b0; bus.req0_op = 3'b000; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_valid = 1'b0; bus.req1_op = 3'b000; bus.req1_a = '0; bus.req1_b = '0;
        bus.rsp_ready  = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Issue one op on a requester, wait for acceptance and response, then hand the response off.
    task automatic run_op(input logic which, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic ok, output int lat, output logic [31:0] data, output logic zero,
                          output logic err, output logic rid, output logic [2:0] ctl, output logic valid_after);
        logic rdy;
        ok = 1'b0; lat = 0; data = '0; zero = 1'b0; err = 1'b0; rid = 1'b0; ctl = '0; valid_after = 1'b1;
        if (which) begin bus.req1_op = op; bus.req1_a = a; bus.req1_b = b; bus.req1_valid = 1'b1; end
        else       begin bus.req0_op = op; bus.req0_a = a; bus.req0_b = b; bus.req0_valid = 1'b1; end
        for (int i = 0; i < 8; i++) begin
            #1 rdy = which ? bus.req1_ready : bus.req0_ready;
            @(posedge clk);
            if (rdy) begin ok = 1'b1; break; end
        end
        #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        if (!ok) return;
        while (!bus.rsp_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!bus.rsp_valid) begin ok = 1'b0; return; end
        data = bus.rsp_data; zero = bus.rsp_zero; err = bus.rsp_err; rid = bus.rsp_id;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        valid_after = bus.rsp_valid;
        ctl = bus.alu_control;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin tests_failed++;
            $display("FAIL reset_readys: got %b want 00", {bus.req0_ready, bus.req1_ready}); end
        tests_run++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_zero, bus.rsp_err, bus.busy} !== 5'b0) begin tests_failed++;
            $display("FAIL reset_flags: got %b want 00000", {bus.rsp_valid, bus.rsp_id, bus.rsp_zero, bus.rsp_err, bus.busy}); end
        tests_run++;
        if ({bus.rsp_data, bus.alu_a, bus.alu_b, bus.alu_control} !== 99'b0) begin tests_failed++;
            $display("FAIL reset_data: data=%h a=%h b=%h ctl=%b want all 0", bus.rsp_data, bus.alu_a, bus.alu_b, bus.alu_control); end
        idle_inputs();
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_add_basic();
        logic ok, z, e, id, va; int lat; logic [31:0] d; logic [2:0] c;
        run_op(1'b0, 3'b010, 32'd5, 32'd7, ok, lat, d, z, e, id, c, va);
        tests_run++;
        if (ok !== 1'b1 || lat != 1) begin tests_failed++;
            $display("FAIL add_latency: ok=%b lat=%0d want ok=1 lat=1", ok, lat); end
        tests_run++;
        if ({d, id, z, e} !== {32'd12, 1'b0, 1'b0, 1'b0}) begin tests_failed++;
            $display("FAIL add_result: data=%0d id=%b zero=%b err=%b want 12 0 0 0", d, id, z, e); end
        tests_run++;
        if (va !== 1'b0 || bus.busy !== 1'b0) begin tests_failed++;
            $display("FAIL add_handoff: rsp_valid=%b busy=%b want 0 0", va, bus.busy); end
    endtask

    task automatic test_round_robin();
        int acc_cyc[$];
        logic acc_id[$];
        int both_hi;
        apply_reset();
        both_hi = 0;
        bus.rsp_ready = 1'b1;
        bus.req0_op = 3'b010; bus.req0_a = 32'd1; bus.req0_b = 32'd2; bus.req0_valid = 1'b1;
        bus.req1_op = 3'b001; bus.req1_a = 32'd4; bus.req1_b = 32'd8; bus.req1_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.req0_ready && bus.req1_ready) both_hi++;
            if (bus.req0_ready) begin acc_cyc.push_back(c); acc_id.push_back(1'b0); end
            else if (bus.req1_ready) begin acc_cyc.push_back(c); acc_id.push_back(1'b1); end
        end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        @(posedge clk); #1 bus.rsp_ready = 1'b0;
        tests_run++;
        if (acc_cyc.size() != 4 || both_hi != 0) begin tests_failed++;
            $display("FAIL rr_count: accepts=%0d both_ready=%0d want 4 0", acc_cyc.size(), both_hi); end
        else begin
            tests_run++;
            if ({acc_id[0], acc_id[1], acc_id[2], acc_id[3]} !== 4'b0101) begin tests_failed++;
                $display("FAIL rr_order: got %b%b%b%b want 0101", acc_id[0], acc_id[1], acc_id[2], acc_id[3]); end
            tests_run++;
            if (acc_cyc[0] != 0 || acc_cyc[1] != 3 || acc_cyc[2] != 6 || acc_cyc[3] != 9) begin tests_failed++;
                $display("FAIL rr_spacing: got %0d %0d %0d %0d want 0 3 6 9", acc_cyc[0], acc_cyc[1], acc_cyc[2], acc_cyc[3]); end
        end
    endtask

    task automatic test_arith_edges();
        logic ok, z, e, id, va; int lat; logic [31:0] d; logic [2:0] c;
        run_op(1'b1, 3'b110, 32'd9, 32'd9, ok, lat, d, z, e, id, c, va);
        tests_run++;
        if ({ok, d, z, id, e} !== {1'b1, 32'd0, 1'b1, 1'b1, 1'b0}) begin tests_failed++;
            $display("FAIL sub_zero: ok=%b data=%h zero=%b id=%b err=%b want 1 0 1 1 0", ok, d, z, id, e); end
        run_op(1'b0, 3'b111, 32'd3, 32'hFFFFFFFF, ok, lat, d, z, e, id, c, va);
        tests_run++;
        if ({ok, d, z, id} !== {1'b1, 32'd1, 1'b0, 1'b0}) begin tests_failed++;
            $display("FAIL slt_unsigned: ok=%b data=%h zero=%b id=%b want 1 1 0 0", ok, d, z, id); end
        run_op(1'b0, 3'b010, 32'hFFFFFFFF, 32'd1, ok, lat, d, z, e, id, c, va);
        tests_run++;
        if ({ok, d, z} !== {1'b1, 32'd0, 1'b1}) begin tests_failed++;
            $display("FAIL add_wrap: ok=%b data=%h zero=%b want 1 0 1", ok, d, z); end
    endtask

    task automatic test_illegal_op();
        logic ok, z, e, id, va; int lat; logic [31:0] d; logic [2:0] c;
        run_op(1'b0, 3'b011, 32'd6, 32'd6, ok, lat, d, z, e, id, c, va);
        tests_run++;
        if (ok !== 1'b1 || lat != 0) begin tests_failed++;
            $display("FAIL illegal_latency: ok=%b lat=%0d want 1 0", ok, lat); end
        tests_run++;
        if ({e, d, z, id} !== {1'b1, 32'd0, 1'b0, 1'b0}) begin tests_failed++;
            $display("FAIL illegal_rsp: err=%b data=%h zero=%b id=%b want 1 0 0 0", e, d, z, id); end
        tests_run++;
        if (c !== 3'b010) begin tests_failed++;
            $display("FAIL illegal_ctl_hold: alu_control=%b want 010", c); end
    endtask

    task automatic test_backpressure();
        logic rdy;
        bus.req0_op = 3'b001; bus.req0_a = 32'hF0; bus.req0_b = 32'h0F; bus.req0_valid = 1'b1;
        #1 rdy = bus.req0_ready;
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        tests_run++;
        if (rdy !== 1'b1) begin tests_failed++; $display("FAIL bp_accept: ready=%b want 1", rdy); end
        @(posedge clk); #1;
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            tests_run++;
            if ({bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.rsp_zero, bus.rsp_err, bus.req0_ready, bus.req1_ready, bus.busy}
                !== {1'b1, 32'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin tests_failed++;
                $display("FAIL bp_hold[%0d]: valid=%b data=%h id=%b z=%b e=%b rdy=%b%b busy=%b want 1 ff 0 0 0 00 1",
                         i, bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.rsp_zero, bus.rsp_err,
                         bus.req0_ready, bus.req1_ready, bus.busy); end
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if ({bus.rsp_valid, bus.busy} !== 2'b00) begin tests_failed++;
            $display("FAIL bp_release: rsp_valid=%b busy=%b want 0 0", bus.rsp_valid, bus.busy); end
        idle_inputs();
    endtask

    task automatic test_reset_mid_exec();
        logic ok, z, e, id, va, rdy; int lat; logic [31:0] d; logic [2:0] c;
        bus.req0_op = 3'b010; bus.req0_a = 32'd4; bus.req0_b = 32'd4; bus.req0_valid = 1'b1;
        #1 rdy = bus.req0_ready;
        @(posedge clk); #1;
        tests_run++;
        if (rdy !== 1'b1 || bus.busy !== 1'b1) begin tests_failed++;
            $display("FAIL rst_exec_entry: ready=%b busy=%b want 1 1", rdy, bus.busy); end
        rst = 1'b1;
        #1;
        tests_run++;
        if ({bus.rsp_valid, bus.busy, bus.req0_ready, bus.req1_ready, bus.alu_control} !== 7'b0
            || bus.alu_a !== 32'd0 || bus.alu_b !== 32'd0) begin tests_failed++;
            $display("FAIL rst_exec_clear: valid=%b busy=%b rdy=%b%b ctl=%b a=%h b=%h want all 0",
                     bus.rsp_valid, bus.busy, bus.req0_ready, bus.req1_ready, bus.alu_control, bus.alu_a, bus.alu_b); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        bus.req0_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({bus.rsp_valid, bus.busy} !== 2'b00) begin tests_failed++;
            $display("FAIL rst_exec_norsp: rsp_valid=%b busy=%b want 0 0", bus.rsp_valid, bus.busy); end
        @(posedge clk); #1;
        run_op(1'b0, 3'b010, 32'd1, 32'd1, ok, lat, d, z, e, id, c, va);
        tests_run++;
        if ({ok, d, id, e} !== {1'b1, 32'd2, 1'b0, 1'b0} || lat != 1) begin tests_failed++;
            $display("FAIL rst_exec_recover: ok=%b data=%h id=%b err=%b lat=%0d want 1 2 0 0 1", ok, d, id, e, lat); end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        bus.alu_data = '0;
        idle_inputs();
        test_reset();
        test_add_basic();
        test_round_robin();
        test_arith_edges();
        test_illegal_op();
        test_backpressure();
        test_reset_mid_exec();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
